// File: rtl/alarm_mode_controller.sv
// Alarm clock mode sequencer: clock / adjust / commit / ringing / snooze.
// Owns the ring, snooze and adjust-inactivity timers.
module alarm_mode_controller #(
   parameter int RING_SEC        = 60,
   parameter int SNOOZE_SEC      = 300,
   parameter int SNOOZE_MAX      = 3,
   parameter int ADJ_TIMEOUT_SEC = 30
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       tick_1hz,
   input  logic       eB1,
   input  logic       eB2,
   input  logic       eB3,
   input  logic       eB4,
   input  logic       alarm_on,
   input  logic       alarm_match,
   output logic       adj_en,
   output logic       commit,
   output logic       buzzer,
   output logic       alarm_led,
   output logic [1:0] disp_sel,
   output logic [2:0] state,
   output logic [1:0] snooze_cnt
);

   localparam int M1 =
      (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int MAXV =
      (M1 > ADJ_TIMEOUT_SEC) ? M1 : ADJ_TIMEOUT_SEC;
   localparam int TW = $clog2(MAXV + 1);

   localparam logic [TW-1:0] RING_T = TW'(RING_SEC);
   localparam logic [TW-1:0] SNZ_T  = TW'(SNOOZE_SEC);
   localparam logic [TW-1:0] ADJ_T  = TW'(ADJ_TIMEOUT_SEC);
   localparam logic [TW-1:0] ONE_T  = TW'(1);
   localparam logic [1:0]    SMAX   = 2'(SNOOZE_MAX);

   typedef enum logic [2:0] {
      S_CLOCK  = 3'd0,
      S_ADJUST = 3'd1,
      S_COMMIT = 3'd2,
      S_RING   = 3'd3,
      S_SNOOZE = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            match_q;
   logic [TW-1:0]   ring_q, ring_d;
   logic [TW-1:0]   snz_q, snz_d;
   logic [TW-1:0]   adj_q, adj_d;
   logic [1:0]      scnt_q, scnt_d;
   logic            led_d;
   logic [1:0]      disp_d;
   logic            trig;
   logic [TW-1:0]   ring_inc, adj_inc;

   always_comb begin
      trig     = alarm_on & alarm_match & ~match_q;
      ring_inc = (ring_q == '1) ? ring_q : ring_q + ONE_T;
      adj_inc  = (adj_q == '1) ? adj_q : adj_q + ONE_T;
      state_d  = state_q;
      ring_d   = ring_q;
      snz_d    = snz_q;
      adj_d    = adj_q;
      scnt_d   = scnt_q;
      case (state_q)
         S_CLOCK: begin
            if (trig) begin
               state_d = S_RING;
            end else if (eB1) begin
               state_d = S_ADJUST;
               adj_d   = '0;
            end
         end
         S_ADJUST: begin
            if (eB1) begin
               state_d = S_COMMIT;
            end else if (eB2 | eB3 | eB4) begin
               adj_d = '0;
            end else if (tick_1hz) begin
               adj_d = adj_inc;
               if (adj_inc >= ADJ_T) state_d = S_CLOCK;
            end
         end
         S_COMMIT: state_d = S_CLOCK;
         S_RING: begin
            if (!alarm_on || eB2) begin
               state_d = S_CLOCK;
            end else if (eB3) begin
               if (scnt_q < SMAX) begin
                  state_d = S_SNOOZE;
                  scnt_d  = scnt_q + 2'd1;
                  snz_d   = SNZ_T;
               end else begin
                  state_d = S_CLOCK;
               end
            end else if (tick_1hz) begin
               ring_d = ring_inc;
               if (ring_inc >= RING_T) state_d = S_CLOCK;
            end
         end
         S_SNOOZE: begin
            if (!alarm_on || eB2) begin
               state_d = S_CLOCK;
            end else if (tick_1hz) begin
               if (snz_q <= ONE_T) begin
                  state_d = S_RING;
                  snz_d   = '0;
               end else begin
                  snz_d = snz_q - ONE_T;
               end
            end
         end
         default: state_d = S_CLOCK;
      endcase
      // Every entry into ringing restarts the ring timer.
      if (state_d == S_RING && state_q != S_RING) ring_d = '0;
      if (state_d == S_CLOCK) scnt_d = '0;
      led_d  = 1'b0;
      disp_d = 2'd0;
      case (state_d)
         S_ADJUST, S_COMMIT: disp_d = 2'd1;
         S_RING: begin
            disp_d = 2'd2;
            if (state_q != S_RING) led_d = 1'b1;
            else led_d = tick_1hz ? ~alarm_led : alarm_led;
         end
         S_SNOOZE: begin
            disp_d = 2'd2;
            led_d  = 1'b1;
         end
         default: disp_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_CLOCK;
         match_q   <= 1'b0;
         ring_q    <= '0;
         snz_q     <= '0;
         adj_q     <= '0;
         scnt_q    <= '0;
         adj_en    <= 1'b0;
         commit    <= 1'b0;
         buzzer    <= 1'b0;
         alarm_led <= 1'b0;
         disp_sel  <= 2'd0;
      end else begin
         state_q   <= state_d;
         match_q   <= alarm_match;
         ring_q    <= ring_d;
         snz_q     <= snz_d;
         adj_q     <= adj_d;
         scnt_q    <= scnt_d;
         adj_en    <= (state_d == S_ADJUST) ||
                      (state_d == S_COMMIT);
         commit    <= (state_d == S_COMMIT);
         buzzer    <= (state_d == S_RING);
         alarm_led <= led_d;
         disp_sel  <= disp_d;
      end
   end

   assign state      = state_q;
   assign snooze_cnt = scnt_q;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Bench for alarm_mode_controller: directed vector table,
// async-reset sequences and random stimulus against a mode model.
module tb_alarm_mode_controller;

   localparam int RING = 4;
   localparam int SNZ  = 2;
   localparam int SMAX = 3;
   localparam int ADJT = 3;

   logic clk = 1'b0;
   logic RESET = 1'b0;
   logic tick_1hz = 1'b0;
   logic eB1 = 1'b0, eB2 = 1'b0, eB3 = 1'b0, eB4 = 1'b0;
   logic alarm_on = 1'b0, alarm_match = 1'b0;
   logic adj_en, commit, buzzer, alarm_led;
   logic [1:0] disp_sel;
   logic [2:0] state;
   logic [1:0] snooze_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alarm_mode_controller #(
      .RING_SEC(RING),
      .SNOOZE_SEC(SNZ),
      .SNOOZE_MAX(SMAX),
      .ADJ_TIMEOUT_SEC(ADJT)
   ) dut (
      .clk(clk),
      .RESET(RESET),
      .tick_1hz(tick_1hz),
      .eB1(eB1),
      .eB2(eB2),
      .eB3(eB3),
      .eB4(eB4),
      .alarm_on(alarm_on),
      .alarm_match(alarm_match),
      .adj_en(adj_en),
      .commit(commit),
      .buzzer(buzzer),
      .alarm_led(alarm_led),
      .disp_sel(disp_sel),
      .state(state),
      .snooze_cnt(snooze_cnt)
   );

   typedef struct {
      logic [6:0] in;   // {tick, on, match, b4, b3, b2, b1}
      logic [2:0] st;
      logic       bz;
      logic       ae;
      logic       cm;
      logic [1:0] sc;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [6:0] v);
      {tick_1hz, alarm_on, alarm_match, eB4, eB3, eB2, eB1} = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] mk(
      input bit b1, input bit b2, input bit b3, input bit b4,
      input bit tk, input bit on, input bit m);
      return {tk, on, m, b4, b3, b2, b1};
   endfunction

   task automatic add(input logic [6:0] in,
                      input int st, input bit bz,
                      input bit ae, input bit cm,
                      input int sc);
      vec_t v;
      v.in = in;
      v.st = 3'(st);
      v.bz = bz;
      v.ae = ae;
      v.cm = cm;
      v.sc = 2'(sc);
      vq.push_back(v);
   endtask

   function automatic logic [1:0] disp_of(input logic [2:0] s);
      if (s == 3'd0) return 2'd0;
      if (s <= 3'd2) return 2'd1;
      return 2'd2;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, 8'(state), 8'd0);
      chk({tag, "_adj"}, 8'(adj_en), 8'd0);
      chk({tag, "_commit"}, 8'(commit), 8'd0);
      chk({tag, "_buzz"}, 8'(buzzer), 8'd0);
      chk({tag, "_led"}, 8'(alarm_led), 8'd0);
      chk({tag, "_disp"}, 8'(disp_sel), 8'd0);
      chk({tag, "_scnt"}, 8'(snooze_cnt), 8'd0);
   endtask

   // Reference model: mode plus elapsed/remaining seconds.
   int m_md, m_idle, m_ring, m_left, m_used;
   bit m_led, m_prev;

   task automatic model_reset();
      m_md = 0; m_idle = 0; m_ring = 0;
      m_left = 0; m_used = 0; m_led = 0; m_prev = 0;
   endtask

   task automatic model_step(input logic [6:0] v);
      bit tk, on, m, b1, b2, b3, b4, edge_hit;
      int nmd;
      {tk, on, m, b4, b3, b2, b1} = v;
      edge_hit = on && m && !m_prev;
      m_prev = m;
      nmd = m_md;
      if (m_md == 0) begin
         if (edge_hit) nmd = 3;
         else if (b1) begin nmd = 1; m_idle = 0; end
      end else if (m_md == 1) begin
         if (b1) nmd = 2;
         else if (b2 || b3 || b4) m_idle = 0;
         else if (tk) begin
            m_idle++;
            if (m_idle >= ADJT) nmd = 0;
         end
      end else if (m_md == 2) begin
         nmd = 0;
      end else if (m_md == 3) begin
         if (!on || b2) nmd = 0;
         else if (b3) begin
            if (m_used < SMAX) begin
               m_used++; m_left = SNZ; nmd = 4;
            end else nmd = 0;
         end else if (tk) begin
            m_ring++;
            if (m_ring >= RING) nmd = 0;
         end
      end else begin
         if (!on || b2) nmd = 0;
         else if (tk) begin
            m_left--;
            if (m_left <= 0) nmd = 3;
         end
      end
      if (nmd == 3) m_led = (m_md != 3) ? 1'b1 : (tk ? !m_led : m_led);
      else m_led = (nmd == 4);
      if (nmd == 3 && m_md != 3) m_ring = 0;
      if (nmd == 0) m_used = 0;
      m_md = nmd;
   endtask

   initial begin
      logic [6:0] v;
      bit rm;
      vec_t r;

      // Ring then stop, no retrigger while match held
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,1,0,0,0,1,1), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,1), 0,0,0,0,0);
      add(mk(0,0,0,0,1,1,1), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      // Adjust and commit
      add(mk(1,0,0,0,0,1,0), 1,0,1,0,0);
      add(mk(0,0,1,0,0,1,0), 1,0,1,0,0);
      add(mk(0,0,1,0,0,1,0), 1,0,1,0,0);
      add(mk(1,0,0,0,0,1,0), 2,0,1,1,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      // Adjust abort, then eB4 keeps it alive
      add(mk(1,0,0,0,0,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 0,0,0,0,0);
      add(mk(1,0,0,0,0,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 1,0,1,0,0);
      add(mk(0,0,0,1,0,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,1,1,0), 1,0,1,0,0);
      add(mk(1,0,0,0,0,1,0), 2,0,1,1,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      // Match edge lost while adjusting
      add(mk(1,0,0,0,0,1,0), 1,0,1,0,0);
      add(mk(0,0,0,0,0,1,1), 1,0,1,0,0);
      add(mk(1,0,0,0,0,1,1), 2,0,1,1,0);
      add(mk(0,0,0,0,0,1,1), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      // Snooze limit
      add(mk(0,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,0,1,0,0,1,0), 4,0,0,0,1);
      add(mk(0,0,0,0,1,1,0), 4,0,0,0,1);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,1);
      add(mk(0,0,1,0,0,1,0), 4,0,0,0,2);
      add(mk(0,0,0,0,1,1,0), 4,0,0,0,2);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,2);
      add(mk(0,0,1,0,0,1,0), 4,0,0,0,3);
      add(mk(0,0,0,0,1,1,0), 4,0,0,0,3);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,3);
      add(mk(0,0,1,0,0,1,0), 0,0,0,0,0);
      // Ring timeout
      add(mk(0,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,0);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,0);
      add(mk(0,0,0,0,1,1,0), 3,1,0,0,0);
      add(mk(0,0,0,0,1,1,0), 0,0,0,0,0);
      // Simultaneity and ignored buttons
      add(mk(1,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,1,1,0,0,1,0), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(1,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,0,0,1,0,1,1), 3,1,0,0,0);
      add(mk(0,0,0,0,0,0,1), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,0), 0,0,0,0,0);
      add(mk(0,0,0,0,0,1,1), 3,1,0,0,0);
      add(mk(0,0,1,0,0,1,0), 4,0,0,0,1);
      add(mk(0,0,1,0,0,1,0), 4,0,0,0,1);
      add(mk(0,1,0,0,0,1,0), 0,0,0,0,0);

      #12;
      chk_all_zero("reset");
      RESET = 1'b1;

      foreach (vq[i]) begin
         r = vq[i];
         drive(r.in);
         step();
         chk($sformatf("v%0d_state", i), 8'(state), 8'(r.st));
         chk($sformatf("v%0d_buzz", i), 8'(buzzer), 8'(r.bz));
         chk($sformatf("v%0d_adj", i), 8'(adj_en), 8'(r.ae));
         chk($sformatf("v%0d_commit", i), 8'(commit), 8'(r.cm));
         chk($sformatf("v%0d_scnt", i), 8'(snooze_cnt), 8'(r.sc));
         chk($sformatf("v%0d_disp", i), 8'(disp_sel),
             8'(disp_of(r.st)));
      end

      // Async reset while snoozing
      drive(mk(0,0,0,0,0,1,1));
      step();
      drive(mk(0,0,1,0,0,1,0));
      step();
      chk("pre_rst_snz", 8'(state), 8'd4);
      drive(7'd0);
      #3 RESET = 1'b0;
      #1 chk_all_zero("rst_snz");
      #2 RESET = 1'b1;
      step();
      chk("post_rst_snz", 8'(state), 8'd0);

      // Async reset during the commit cycle
      drive(mk(1,0,0,0,0,1,0));
      step();
      drive(mk(1,0,0,0,0,1,0));
      step();
      chk("pre_rst_cm", 8'(commit), 8'd1);
      drive(7'd0);
      #2 RESET = 1'b0;
      #1 chk_all_zero("rst_cm");
      #2 RESET = 1'b1;
      step();
      chk("post_rst_cm_state", 8'(state), 8'd0);
      chk("post_rst_cm_commit", 8'(commit), 8'd0);

      // Random stimulus against the model
      RESET = 1'b0;
      drive(7'd0);
      model_reset();
      #7 RESET = 1'b1;
      rm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rm = !rm;
         v[0] = ($urandom_range(0, 9) == 0);
         v[1] = ($urandom_range(0, 11) == 0);
         v[2] = ($urandom_range(0, 5) == 0);
         v[3] = ($urandom_range(0, 9) == 0);
         v[4] = rm;
         v[5] = ($urandom_range(0, 39) != 0);
         v[6] = ($urandom_range(0, 2) == 0);
         model_step(v);
         drive(v);
         step();
         chk($sformatf("r%0d_state", i), 8'(state), 8'(m_md));
         chk($sformatf("r%0d_buzz", i), 8'(buzzer),
             8'(m_md == 3));
         chk($sformatf("r%0d_adj", i), 8'(adj_en),
             8'(m_md == 1 || m_md == 2));
         chk($sformatf("r%0d_commit", i), 8'(commit),
             8'(m_md == 2));
         chk($sformatf("r%0d_led", i), 8'(alarm_led), 8'(m_led));
         chk($sformatf("r%0d_scnt", i), 8'(snooze_cnt),
             8'(m_used));
         chk($sformatf("r%0d_disp", i), 8'(disp_sel),
             8'(disp_of(3'(m_md))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_mode_controller.md
Name: alarm_mode_controller

Overview:
- Top-level mode sequencer for the digital alarm clock.
- Decides which of three modes owns the shared display and buttons: normal timekeeping, adjust mode, or alarm ringing/snooze.
- Drives the adjust-mode enable, issues the commit strobe that writes adjusted clock/alarm values back into the timekeeping and alarm registers, and runs the ring, snooze and adjust-inactivity timers.
- Sits between the debounced/edge-detected button pulses and the adjust, timekeeping, alarm-compare and buzzer logic.

Parameters:
- RING_SEC, 60, seconds the buzzer sounds before auto-stop.
- SNOOZE_SEC, 300, snooze interval in seconds.
- SNOOZE_MAX, 3, snoozes allowed per alarm event; the next snooze request acts as stop.
- ADJ_TIMEOUT_SEC, 30, seconds of no button activity in adjust mode before abort.

Ports:
- clk  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk.
- eB1  in  1  mode button pulse (one cycle, already debounced and edge-detected).
- eB2  in  1  stop button pulse.
- eB3  in  1  snooze / up button pulse.
- eB4  in  1  down button pulse.
- alarm_on  in  1  alarm-enable switch level.
- alarm_match  in  1  level; high while current time equals alarm time.
- adj_en  out  1  enable for the adjust-mode datapath (its enIN); load happens on the 0->1 edge.
- commit  out  1  one-cycle strobe; downstream registers capture adjusted clock and alarm values.
- buzzer  out  1  buzzer drive.
- alarm_led  out  1  toggles on every tick while ringing, steady high in snooze, else 0.
- disp_sel  out  2  display owner: 0 = clock, 1 = adjust, 2 = alarm/snooze.
- state  out  3  current FSM state, for debug.
- snooze_cnt  out  2  snoozes used in the current alarm event.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=CLOCK.
  - All outputs 0.
  - Internal timers and the alarm_match history register cleared.
- States are encoded CLOCK=0, ADJUST=1, COMMIT=2, RINGING=3, SNOOZE=4. All transitions are registered; outputs are decoded from state, except commit, which is high exactly in COMMIT.
- Alarm trigger: trig = alarm_on & alarm_match & ~match_q, where match_q is alarm_match delayed one cycle. Only a 0->1 match edge triggers.
- CLOCK:
  - disp_sel=0, adj_en=0.
  - trig -> RINGING; this has priority over eB1 in the same cycle.
  - eB1 -> ADJUST; clear the inactivity timer.
- ADJUST:
  - adj_en=1, disp_sel=1.
  - eB1 -> COMMIT.
  - Any of eB2/eB3/eB4 clears the inactivity timer.
  - Each tick with no button pulse increments the timer. Reaching ADJ_TIMEOUT_SEC -> CLOCK with no commit (abort).
  - trig is ignored; the match edge is lost.
- COMMIT:
  - Lasts exactly one cycle, with commit=1 and adj_en=1 still held so the data presented to downstream registers stays valid.
  - Unconditionally -> CLOCK.
- RINGING:
  - buzzer=1, disp_sel=2.
  - Entry from CLOCK: snooze_cnt=0, ring timer=0. Entry from SNOOZE: ring timer=0, snooze_cnt kept.
  - Priority, highest first:
    1. alarm_on=0 -> CLOCK.
    2. eB2 -> CLOCK.
    3. eB3 with snooze_cnt<SNOOZE_MAX -> SNOOZE; snooze_cnt+1, snooze timer loaded with SNOOZE_SEC.
    4. eB3 with snooze_cnt==SNOOZE_MAX -> CLOCK.
    5. Ring timer reaches RING_SEC on a tick -> CLOCK.
  - eB1 and eB4 are ignored.
- SNOOZE:
  - buzzer=0, alarm_led=1, disp_sel=2.
  - The snooze timer decrements on each tick; at 0 -> RINGING.
  - alarm_on=0 or eB2 -> CLOCK, with the same priority as in RINGING.
  - eB1, eB3 and eB4 are ignored.
- Timers:
  - Width is clog2(max parameter + 1).
  - Timers saturate and never wrap.
  - Timers advance only on tick_1hz.
- snooze_cnt clears when CLOCK is entered.
- An illegal state encoding recovers to CLOCK on the next cycle.
- Reset asserted in any state returns to the reset values immediately. A commit in flight is dropped.

Test Plan:
- Ring then stop: reset, alarm_on=1, raise alarm_match → state 0->3 after 1 cycle and buzzer=1. Pulse eB2 → state=0 and buzzer=0 the next cycle. Hold match high → no retrigger.
- Adjust and commit: eB1 → adj_en=1, disp_sel=1. eB3 twice, then eB1 → commit high for exactly one cycle with adj_en=1 in that cycle, then state=0 and adj_en=0.
- Adjust abort: with ADJ_TIMEOUT_SEC=3, enter ADJUST and apply 3 ticks with no buttons → state=0 and commit never asserted. Repeat with an eB4 after the 2nd tick → still in ADJUST after the 3rd tick.
- Snooze limit: SNOOZE_SEC=2, SNOOZE_MAX=3.
  - Trigger, eB3 → SNOOZE with snooze_cnt=1; after 2 ticks → RINGING.
  - Repeat until snooze_cnt=3.
  - A 4th eB3 → CLOCK with snooze_cnt=0.
- Ring timeout and simultaneity:
  - RING_SEC=4: 4 ticks in RINGING → CLOCK.
  - eB1 in the same cycle as trig in CLOCK → RINGING, not ADJUST.
  - eB2 with eB3 in the same cycle in RINGING → CLOCK.
- Reset mid-operation: assert RESET=0 in SNOOZE and in COMMIT, asynchronously between clock edges → all outputs 0 immediately, state=0 after release.
